// File: rtl/addsub16_nibble_seq_pkg.sv
// Shared constants and types for the nibble-serial 16-bit adder/subtractor.
// The control struct bundles FSM state, nibble index and carry so they can be probed as one item.
package addsub16_nibble_seq_pkg;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;
  localparam int NPASS = WIDTH / NIB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] idx;
    logic       carry;
  } ctl_t;

  localparam logic [1:0] LAST_IDX = 2'(NPASS - 1);

endpackage

// File: rtl/fullAddSub_mux_4b.sv
// 4-bit add/sub slice: B is muxed between true and inverted form, then added with carry-in.
// Subtract needs the caller to supply c_in = 1 for the two's-complement +1.
module fullAddSub_mux_4b (
  input  logic [3:0] inA,
  input  logic [3:0] inB,
  input  logic       c_in,
  input  logic       add_sub_sel,
  output logic [3:0] out,
  output logic       c_out
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  assign b_eff = add_sub_sel ? ~inB : inB;
  assign sum   = {1'b0, inA} + {1'b0, b_eff} + {4'b0000, c_in};
  assign out   = sum[3:0];
  assign c_out = sum[4];

endmodule

// File: rtl/addsub16_nibble_seq.sv
// Nibble-serial 16-bit add/sub: one 4-bit slice reused over four clocks, LSB nibble first.
// Carry is registered between passes; result, carry-out and signed overflow finish in DONE.
module addsub16_nibble_seq
  import addsub16_nibble_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             add_sub_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf
);

  ctl_t ctl_q, ctl_d;
  logic accept;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             sel_q;
  logic             c_out_q, ovf_q;

  logic [3:0]     nib_base;
  logic [NIB-1:0] slice_a, slice_b, slice_out;
  logic           slice_c;
  logic           run, last_pass, ovf_calc;

  assign run       = (ctl_q.state == RUN);
  assign last_pass = run && (ctl_q.idx == LAST_IDX);
  assign nib_base  = {ctl_q.idx, 2'b00};
  assign slice_a   = a_q[nib_base +: NIB];
  assign slice_b   = b_q[nib_base +: NIB];

  fullAddSub_mux_4b u_slice (
    .inA         (slice_a),
    .inB         (slice_b),
    .c_in        (ctl_q.carry),
    .add_sub_sel (sel_q),
    .out         (slice_out),
    .c_out       (slice_c)
  );

  // On the last pass the slice's MSB is the result sign bit R[15].
  always_comb begin
    ovf_calc = 1'b0;
    if (sel_q) ovf_calc = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_out[NIB-1] != a_q[WIDTH-1]);
    else       ovf_calc = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_out[NIB-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q <= '{state: IDLE, idx: 2'd0, carry: 1'b0};
    end else begin
      ctl_q <= ctl_d;
    end
  end

  always_comb begin
    ctl_d  = ctl_q;
    accept = 1'b0;
    case (ctl_q.state)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      RUN: begin
        ctl_d.idx   = ctl_q.idx + 2'd1;
        ctl_d.carry = slice_c;
        if (ctl_q.idx == LAST_IDX) ctl_d.state = DONE;
      end
      DONE: begin
        if (start) accept = 1'b1;
        else       ctl_d.state = IDLE;
      end
      default: ctl_d.state = IDLE;
    endcase
    // The carry seeds with the select so subtract gets its +1.
    if (accept) begin
      ctl_d.state = RUN;
      ctl_d.idx   = 2'd0;
      ctl_d.carry = add_sub_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      res_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= inA;
        b_q   <= inB;
        sel_q <= add_sub_sel;
      end
      if (run) res_q[nib_base +: NIB] <= slice_out;
      if (last_pass) begin
        c_out_q <= slice_c;
        ovf_q   <= ovf_calc;
      end
    end
  end

  assign busy  = run;
  assign done  = (ctl_q.state == DONE);
  assign out   = res_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_addsub16_nibble_seq.sv
// Scoreboard bench for addsub16_nibble_seq: directed corners plus randomized requests
// checked against an integer-arithmetic reference model.
module tb_addsub16_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        sel = 1'b0;
  logic        busy, done, c_out, ovf;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = -1;

  // expected {ovf, c_out, out}
  logic [17:0] exp_q[$];

  addsub16_nibble_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inA         (in_a),
    .inB         (in_b),
    .add_sub_sel (sel),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .c_out       (c_out),
    .ovf         (ovf)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa, sb, sr;
    logic [16:0] u;
    logic c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      u  = {1'b0, a} + {1'b0, b};
      sr = sa + sb;
      c  = u[16];
    end else begin
      u  = {1'b0, a} - {1'b0, b};
      sr = sa - sb;
      c  = (a >= b);
    end
    v = (sr > 32767) || (sr < -32768);
    return {v, c, u[15:0]};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("out", 32'(out), 32'(e[15:0]));
        check("c_out", 32'(c_out), 32'(e[16]));
        check("ovf", 32'(ovf), 32'(e[17]));
      end
    end
  end

  // driver: present a request once the block can accept it, hold start for one edge
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_timeout", 32'd1, 32'd0);
    in_a  = a;
    in_b  = b;
    sel   = s;
    start = 1'b1;
    exp_q.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = 16'($urandom);
    in_b  = 16'($urandom);
    sel   = 1'($urandom);
  endtask

  // request plus timing check: 4 busy cycles, done on the 5th cycle after acceptance
  task automatic run_timed(input logic [15:0] a, input logic [15:0] b, input logic s);
    int busy_cnt, waits;
    busy_cnt = 0;
    waits = 0;
    issue(a, b, s);
    @(negedge clk);
    while (!done && waits < 20) begin
      if (busy) busy_cnt++;
      waits++;
      @(negedge clk);
    end
    check("done_latency", 32'(waits), 32'd4);
    check("busy_cycles", 32'(busy_cnt), 32'd4);
    check("busy_in_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int first_done, n;
    logic [15:0] a2, b2;
    logic s2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    run_timed(16'h1234, 16'h4321, 1'b0);
    run_timed(16'hFFFF, 16'h0001, 1'b0);
    run_timed(16'h7FFF, 16'h0001, 1'b0);
    run_timed(16'h0005, 16'h0007, 1'b1);
    run_timed(16'h8000, 16'h0001, 1'b1);
    wait_drain();

    // start held through RUN with changing operands; only the DONE-cycle request counts
    @(negedge clk);
    in_a = 16'hA5A5; in_b = 16'h1111; sel = 1'b1; start = 1'b1;
    exp_q.push_back(model(16'hA5A5, 16'h1111, 1'b1));
    n = 0;
    first_done = -1;
    a2 = 16'h9C3E; b2 = 16'h63C2; s2 = 1'b0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      in_a = 16'($urandom); in_b = 16'($urandom); sel = 1'($urandom);
      @(negedge clk);
      n++;
      if (done) begin
        first_done = cyc;
        in_a = a2; in_b = b2; sel = s2;
        exp_q.push_back(model(a2, b2, s2));
        break;
      end
    end
    check("held_first_done_seen", 32'(first_done >= 0), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom);
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("back_to_back_spacing", 32'(cyc - first_done), 32'd5);
    wait_drain();

    // reset in the third RUN cycle discards the request
    @(negedge clk);
    in_a = 16'h0F0F; in_b = 16'h0101; sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_c_out", 32'(c_out), 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_timed(16'h8001, 16'h8001, 1'b0);
    wait_drain();

    // randomized requests, mostly back-to-back
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom));
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
